// File: rtl/sad_pkg.sv
// Shared definitions for the SAD pattern trigger: register map, sample and threshold
// widths, STATUS layout and the absolute-difference helper.
package sad_pkg;

    localparam logic [7:0] SAD_STATUS            = 8'h60;
    localparam logic [7:0] SAD_REFERENCE_BASE    = 8'h61;
    localparam logic [7:0] SAD_REFERENCE         = 8'h62;
    localparam logic [7:0] SAD_REFEN             = 8'h63;
    localparam logic [7:0] SAD_THRESHOLD         = 8'h64;
    localparam logic [7:0] SAD_MULTIPLE_TRIGGERS = 8'h65;

    localparam int unsigned REF_SAMPLE_W      = 8;
    localparam int unsigned THRESH_W          = 32;
    localparam int unsigned THRESH_BYTES      = THRESH_W / 8;
    localparam int unsigned STATUS_FLAG_BYTE  = 0;
    localparam int unsigned STATUS_COUNT_BYTE = 1;

    typedef struct packed {
        logic [7:0] trig_count;
        logic       triggered;
    } sad_status_t;

    function automatic logic [REF_SAMPLE_W-1:0] abs_diff(
        input logic [REF_SAMPLE_W-1:0] a,
        input logic [REF_SAMPLE_W-1:0] b
    );
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sad_usb_reg.sv
// USB bus front end for the SAD trigger: strobe synchronisation, byte counter,
// register file with read-back mux and reference sample RAM.
module sad_usb_reg
    import sad_pkg::*;
#(
    parameter int unsigned pBYTECNT_SIZE = 7,
    parameter int unsigned pREF_SAMPLES  = 8
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic [7:0]                         i_addr,
    input  logic [7:0]                         i_wdata,
    input  logic                               i_rdn,
    input  logic                               i_wrn,
    input  logic                               i_cen,
    input  logic                               i_alen,
    input  sad_status_t                        i_status,
    output logic [7:0]                         o_rdata_c,
    output logic                               o_oe_c,
    output logic [pREF_SAMPLES-1:0][7:0]       o_ref,
    output logic [pREF_SAMPLES-1:0]            o_refen,
    output logic [THRESH_W-1:0]                o_threshold,
    output logic                               o_multi_en
);

    localparam int unsigned N           = pREF_SAMPLES;
    localparam int unsigned REFEN_BYTES = N / 8;
    localparam int unsigned IDX_W       = $clog2(N);
    localparam int unsigned EN_IDX_W    = (REFEN_BYTES > 1) ? $clog2(REFEN_BYTES) : 1;
    localparam int unsigned THR_IDX_W   = $clog2(THRESH_BYTES);

    logic                                r_wrn_meta, r_wrn_sync, r_wrn_prev;
    logic                                r_rdn_meta, r_rdn_sync, r_rdn_prev;
    logic [pBYTECNT_SIZE-1:0]            r_bytecnt;
    logic [7:0]                          r_base;
    logic [N-1:0][7:0]                   r_ref;
    logic [REFEN_BYTES-1:0][7:0]         r_refen;
    logic [THRESH_BYTES-1:0][7:0]        r_thr;
    logic [7:0]                          r_multi;

    logic        w_wr_stb, w_rd_stb;
    logic [15:0] w_k, w_ref_idx;
    logic        w_ref_hit, w_en_hit, w_thr_hit;

    assign w_wr_stb  = r_wrn_prev & ~r_wrn_sync & ~i_cen;
    assign w_rd_stb  = ~r_rdn_prev & r_rdn_sync & ~i_cen;
    assign w_k       = 16'(r_bytecnt);
    assign w_ref_idx = 16'({r_base, 7'b0}) + w_k;
    assign w_ref_hit = w_ref_idx < 16'(N);
    assign w_en_hit  = w_k < 16'(REFEN_BYTES);
    assign w_thr_hit = w_k < 16'(THRESH_BYTES);

    // Strobe synchronisers and the per-access byte counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrn_meta <= 1'b1;
            r_wrn_sync <= 1'b1;
            r_wrn_prev <= 1'b1;
            r_rdn_meta <= 1'b1;
            r_rdn_sync <= 1'b1;
            r_rdn_prev <= 1'b1;
            r_bytecnt  <= '0;
        end else begin
            r_wrn_meta <= i_wrn;
            r_wrn_sync <= r_wrn_meta;
            r_wrn_prev <= r_wrn_sync;
            r_rdn_meta <= i_rdn;
            r_rdn_sync <= r_rdn_meta;
            r_rdn_prev <= r_rdn_sync;
            if (!i_alen) begin
                r_bytecnt <= '0;
            end else if (w_wr_stb || w_rd_stb) begin
                r_bytecnt <= r_bytecnt + pBYTECNT_SIZE'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_base  <= '0;
            r_ref   <= '0;
            r_refen <= '0;
            r_thr   <= '0;
            r_multi <= '0;
        end else if (w_wr_stb) begin
            case (i_addr)
                SAD_REFERENCE_BASE:    r_base <= i_wdata;
                SAD_REFERENCE:         if (w_ref_hit) r_ref[w_ref_idx[IDX_W-1:0]] <= i_wdata;
                SAD_REFEN:             if (w_en_hit) r_refen[w_k[EN_IDX_W-1:0]] <= i_wdata;
                SAD_THRESHOLD:         if (w_thr_hit) r_thr[w_k[THR_IDX_W-1:0]] <= i_wdata;
                SAD_MULTIPLE_TRIGGERS: r_multi <= i_wdata;
                default:               ;
            endcase
        end
    end

    always_comb begin
        o_rdata_c = '0;
        case (i_addr)
            SAD_STATUS: begin
                if (w_k == 16'(STATUS_FLAG_BYTE)) begin
                    o_rdata_c = {7'b0, i_status.triggered};
                end else if (w_k == 16'(STATUS_COUNT_BYTE)) begin
                    o_rdata_c = i_status.trig_count;
                end
            end
            SAD_REFERENCE_BASE:    o_rdata_c = r_base;
            SAD_REFERENCE:         if (w_ref_hit) o_rdata_c = r_ref[w_ref_idx[IDX_W-1:0]];
            SAD_REFEN:             if (w_en_hit) o_rdata_c = r_refen[w_k[EN_IDX_W-1:0]];
            SAD_THRESHOLD:         if (w_thr_hit) o_rdata_c = r_thr[w_k[THR_IDX_W-1:0]];
            SAD_MULTIPLE_TRIGGERS: o_rdata_c = r_multi;
            default:               o_rdata_c = '0;
        endcase
    end

    assign o_oe_c      = ~i_cen & ~i_rdn & i_rst_n;
    assign o_ref       = r_ref;
    assign o_refen     = r_refen;
    assign o_threshold = r_thr;
    assign o_multi_en  = r_multi[0];

endmodule

// File: rtl/sad_wrapper.sv
// SAD pattern trigger: sliding ADC window vs stored reference, 5-stage pipelined sum.
// Define SAD_TRIGGER_COUNT_EN to include the saturating trigger counter (STATUS byte 1).
module sad_wrapper
    import sad_pkg::*;
#(
    parameter int unsigned pBYTECNT_SIZE    = 7,
    parameter int unsigned pREF_SAMPLES     = 8,
    parameter int unsigned pBITS_PER_SAMPLE = 12
) (
    input  logic                        clk_adc,
    input  logic                        reset_n,
    input  logic [pBITS_PER_SAMPLE-1:0] adc_datain,
    input  logic                        armed_and_ready,
    input  logic [7:0]                  USB_Addr,
    inout  wire  [7:0]                  USB_Data,
    input  logic                        USB_RDn,
    input  logic                        USB_WRn,
    input  logic                        USB_CEn,
    input  logic                        USB_ALEn,
    output logic                        trigger
);

    localparam int unsigned N      = pREF_SAMPLES;
    localparam int unsigned GROUPS = N / 8;
    localparam int unsigned PART_W = $clog2(8 * 255 + 1);
    localparam int unsigned SUM_W  = $clog2(N * 255 + 1);
    localparam int unsigned FILL_W = $clog2(N + 1);
    localparam int unsigned HOLD_W = $clog2(N);

    logic [N-1:0][7:0]     w_ref;
    logic [N-1:0]          w_refen;
    logic [THRESH_W-1:0]   w_threshold;
    logic                  w_multi_en;
    logic [7:0]            w_rdata;
    logic                  w_oe;
    logic [7:0]            w_sample;
    logic                  w_unused_adc;
    logic [7:0]            w_trig_count;
    sad_status_t           w_status;

    logic [N-1:0][7:0]          r_win, r_diff, w_diff;
    logic [FILL_W-1:0]          r_fill;
    logic [GROUPS-1:0][PART_W-1:0] r_part, w_part;
    logic [SUM_W-1:0]           r_sum, w_sum;
    logic                       r_v1, r_v2, r_v3, r_match;
    logic [HOLD_W-1:0]          r_hold;
    logic                       r_armed_d, r_flag;
    logic                       w_arm_rise, w_fire;

    sad_usb_reg #(
        .pBYTECNT_SIZE (pBYTECNT_SIZE),
        .pREF_SAMPLES  (pREF_SAMPLES)
    ) u_usb_reg (
        .i_clk       (clk_adc),
        .i_rst_n     (reset_n),
        .i_addr      (USB_Addr),
        .i_wdata     (USB_Data),
        .i_rdn       (USB_RDn),
        .i_wrn       (USB_WRn),
        .i_cen       (USB_CEn),
        .i_alen      (USB_ALEn),
        .i_status    (w_status),
        .o_rdata_c   (w_rdata),
        .o_oe_c      (w_oe),
        .o_ref       (w_ref),
        .o_refen     (w_refen),
        .o_threshold (w_threshold),
        .o_multi_en  (w_multi_en)
    );

    assign USB_Data     = w_oe ? w_rdata : 8'hzz;
    assign w_sample     = adc_datain[pBITS_PER_SAMPLE-1 -: REF_SAMPLE_W];
    assign w_unused_adc = ^adc_datain;

    always_comb begin
        w_diff = '0;
        for (int i = 0; i < N; i++) begin
            if (w_refen[i]) w_diff[i] = abs_diff(r_win[i], w_ref[i]);
        end
    end

    always_comb begin
        w_part = '0;
        for (int g = 0; g < GROUPS; g++) begin
            for (int j = 0; j < 8; j++) begin
                w_part[g] = w_part[g] + PART_W'(r_diff[g*8+j]);
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int g = 0; g < GROUPS; g++) begin
            w_sum = w_sum + SUM_W'(r_part[g]);
        end
    end

    // Newest sample lands in the top element; window[0] is the oldest
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            r_win   <= '0;
            r_fill  <= '0;
            r_diff  <= '0;
            r_v1    <= 1'b0;
            r_part  <= '0;
            r_v2    <= 1'b0;
            r_sum   <= '0;
            r_v3    <= 1'b0;
            r_match <= 1'b0;
        end else begin
            r_win <= {w_sample, r_win[N-1:1]};
            if (r_fill != FILL_W'(N)) r_fill <= r_fill + FILL_W'(1);
            r_diff  <= w_diff;
            r_v1    <= (r_fill == FILL_W'(N));
            r_part  <= w_part;
            r_v2    <= r_v1;
            r_sum   <= w_sum;
            r_v3    <= r_v2;
            r_match <= r_v3 && (THRESH_W'(r_sum) < w_threshold);
        end
    end

    assign w_arm_rise = armed_and_ready & ~r_armed_d;
    assign w_fire     = r_match & armed_and_ready & (r_hold == '0)
                      & (w_multi_en | ~r_flag | w_arm_rise);

    // Trigger qualification: hold-off window, single-shot flag and arm tracking
    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            trigger   <= 1'b0;
            r_hold    <= '0;
            r_armed_d <= 1'b0;
            r_flag    <= 1'b0;
        end else begin
            trigger   <= w_fire;
            r_armed_d <= armed_and_ready;
            if (w_fire) begin
                r_hold <= HOLD_W'(N - 1);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
            end
            if (w_fire) begin
                r_flag <= 1'b1;
            end else if (w_arm_rise) begin
                r_flag <= 1'b0;
            end
        end
    end

`ifdef SAD_TRIGGER_COUNT_EN
    logic [7:0] r_trig_count;

    always_ff @(posedge clk_adc or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_count <= '0;
        end else if (w_fire) begin
            if (w_arm_rise) begin
                r_trig_count <= 8'd1;
            end else if (r_trig_count != 8'hFF) begin
                r_trig_count <= r_trig_count + 8'd1;
            end
        end else if (w_arm_rise) begin
            r_trig_count <= '0;
        end
    end

    assign w_trig_count = r_trig_count;
`else
    assign w_trig_count = '0;
`endif

    assign w_status.trig_count = w_trig_count;
    assign w_status.triggered  = r_flag;

endmodule

// File: tb/tb_sad_wrapper.sv
// Self-checking bench for sad_wrapper: randomized sample stream against a window/sum
// reference model, plus directed register accesses over the USB bus.
`timescale 1ns/1ps
module tb_sad_wrapper;
    import sad_pkg::*;

    localparam int unsigned N   = 8;
    localparam int          NI  = 8;
    localparam int unsigned BPS = 12;

    logic           clk_adc = 1'b0;
    logic           reset_n;
    logic [BPS-1:0] adc_datain;
    logic           armed_and_ready;
    logic [7:0]     usb_addr;
    wire  [7:0]     usb_data;
    logic           usb_rdn, usb_wrn, usb_cen, usb_alen;
    logic           trigger;
    logic           tb_drv;
    logic [7:0]     tb_wdata;

    assign usb_data = tb_drv ? tb_wdata : 8'hzz;

    sad_wrapper #(
        .pBYTECNT_SIZE    (7),
        .pREF_SAMPLES     (N),
        .pBITS_PER_SAMPLE (BPS)
    ) dut (
        .clk_adc         (clk_adc),
        .reset_n         (reset_n),
        .adc_datain      (adc_datain),
        .armed_and_ready (armed_and_ready),
        .USB_Addr        (usb_addr),
        .USB_Data        (usb_data),
        .USB_RDn         (usb_rdn),
        .USB_WRn         (usb_wrn),
        .USB_CEn         (usb_cen),
        .USB_ALEn        (usb_alen),
        .trigger         (trigger)
    );

    always #5 clk_adc = ~clk_adc;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0]  ref_m [N];
    logic [N-1:0] refen_m;
    logic [31:0] thr_m;
    logic        multi_m;
    logic [7:0]  hist [$];
    bit          pipe [$];
    int          nsamp, edge_n, last_trig, cnt_m;
    bit          flag_m, armed_prev;
    int          obs_trigs;

    logic [7:0]  pat [N];
    logic [7:0]  pat_q [$];
    logic [7:0]  wq [$];
    logic [7:0]  rq [$];

`ifdef SAD_TRIGGER_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // One clock: drive a sample, advance the model at the edge, compare trigger
    task automatic tick();
        logic [7:0]  s;
        int unsigned sum;
        bit          m, cand, exp;
        @(negedge clk_adc);
        if (pat_q.size() > 0) s = pat_q.pop_front();
        else s = 8'($urandom);
        adc_datain = {s, 4'($urandom)};
        @(posedge clk_adc);
        exp = 1'b0;
        if (reset_n) begin
            hist.push_back(s);
            if (hist.size() > N) void'(hist.pop_front());
            nsamp++;
            sum = 0;
            if (nsamp >= NI) begin
                for (int i = 0; i < NI; i++) begin
                    if (refen_m[i]) sum += (hist[i] > ref_m[i]) ? (hist[i] - ref_m[i]) : (ref_m[i] - hist[i]);
                end
            end
            m = (nsamp >= NI) && (sum < thr_m);
            pipe.push_back(m);
            cand = pipe.pop_front();
            if (armed_and_ready && !armed_prev) begin
                flag_m = 1'b0;
                cnt_m  = 0;
            end
            armed_prev = armed_and_ready;
            exp = cand && armed_and_ready && (edge_n - last_trig >= NI) && (multi_m || !flag_m);
            if (exp) begin
                last_trig = edge_n;
                flag_m    = 1'b1;
                if (cnt_m < 255) cnt_m++;
            end
            edge_n++;
        end
        #1;
        if (trigger) obs_trigs++;
        check("trigger", 32'(trigger), 32'(exp));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        hist.delete();
        pipe.delete();
        repeat (5) pipe.push_back(1'b0);
        nsamp = 0; last_trig = -1000; cnt_m = 0; flag_m = 1'b0; armed_prev = 1'b0;
        thr_m = '0; refen_m = '0; multi_m = 1'b0;
        for (int i = 0; i < NI; i++) ref_m[i] = '0;
        idle(cycles);
        reset_n = 1'b1;
    endtask

    task automatic bus_addr(input logic [7:0] a);
        usb_addr = a;
        usb_alen = 1'b0;
        idle(2);
        usb_alen = 1'b1;
        tick();
    endtask

    task automatic bus_write(input logic [7:0] a);
        bus_addr(a);
        usb_cen = 1'b0;
        tb_drv  = 1'b1;
        foreach (wq[i]) begin
            tb_wdata = wq[i];
            usb_wrn  = 1'b0;
            idle(4);
            usb_wrn  = 1'b1;
            idle(4);
        end
        usb_cen = 1'b1;
        tb_drv  = 1'b0;
        tick();
    endtask

    task automatic bus_read(input logic [7:0] a, input int n);
        rq.delete();
        bus_addr(a);
        usb_cen = 1'b0;
        for (int i = 0; i < n; i++) begin
            usb_rdn = 1'b0;
            idle(3);
            rq.push_back(usb_data);
            usb_rdn = 1'b1;
            idle(4);
        end
        usb_cen = 1'b1;
        tick();
    endtask

    task automatic set_thr(input logic [31:0] t);
        wq.delete();
        for (int i = 0; i < 4; i++) wq.push_back(t[8*i +: 8]);
        bus_write(SAD_THRESHOLD);
        thr_m = t;
    endtask

    task automatic set_refen(input logic [7:0] e);
        wq.delete();
        wq.push_back(e);
        bus_write(SAD_REFEN);
        refen_m = e;
    endtask

    task automatic set_multi(input logic [7:0] v);
        wq.delete();
        wq.push_back(v);
        bus_write(SAD_MULTIPLE_TRIGGERS);
        multi_m = v[0];
    endtask

    task automatic feed();
        for (int i = 0; i < NI; i++) pat_q.push_back(pat[i]);
        idle(NI);
    endtask

    task automatic base_pattern();
        for (int i = 0; i < NI; i++) pat[i] = 8'((i + 1) * 10);
    endtask

    task automatic check_status(input string tag, input logic [7:0] flag, input logic [7:0] cnt);
        bus_read(SAD_STATUS, 2);
        check({tag, "_flag"}, 32'(rq[0]), 32'(flag));
        check({tag, "_count"}, 32'(rq[1]), CNT_EN ? 32'(cnt) : 32'd0);
    endtask

    initial begin
        armed_and_ready = 1'b0;
        usb_addr = '0; usb_rdn = 1'b1; usb_wrn = 1'b1; usb_cen = 1'b1; usb_alen = 1'b1;
        tb_drv = 1'b0; tb_wdata = '0; adc_datain = '0;
        edge_n = 0; obs_trigs = 0;

        // Reset state
        do_reset(4);
        check_status("rst_status", 8'd0, 8'd0);
        bus_read(SAD_THRESHOLD, 4);
        check("rst_threshold", {rq[3], rq[2], rq[1], rq[0]}, 32'd0);

        // Configuration and read-back
        wq.delete(); wq.push_back(8'h00);
        bus_write(SAD_REFERENCE_BASE);
        base_pattern();
        wq.delete();
        for (int i = 0; i < NI; i++) begin
            wq.push_back(pat[i]);
            ref_m[i] = pat[i];
        end
        bus_write(SAD_REFERENCE);
        set_refen(8'hFF);
        set_thr(32'd1);
        bus_read(SAD_REFERENCE, N);
        for (int i = 0; i < NI; i++) check($sformatf("ref_rb%0d", i), 32'(rq[i]), 32'(pat[i]));
        bus_read(SAD_THRESHOLD, 4);
        check("thr_rb", {rq[3], rq[2], rq[1], rq[0]}, 32'd1);
        bus_read(SAD_REFERENCE_BASE, 1);
        check("base_rb", 32'(rq[0]), 32'd0);

        // Exact match
        armed_and_ready = 1'b1; idle(3); obs_trigs = 0;
        feed(); idle(8);
        check("exact_trigs", 32'(obs_trigs), 32'd1);
        armed_and_ready = 1'b0; idle(2);

        // Threshold boundary: sum 5 against threshold 5 and 6
        pat[3] = pat[3] + 8'd5;
        set_thr(32'd5);
        armed_and_ready = 1'b1; idle(3); obs_trigs = 0;
        feed(); idle(8);
        check("thr5_trigs", 32'(obs_trigs), 32'd0);
        armed_and_ready = 1'b0; idle(2);
        set_thr(32'd6);
        armed_and_ready = 1'b1; idle(3); obs_trigs = 0;
        feed(); idle(8);
        check("thr6_trigs", 32'(obs_trigs), 32'd1);
        armed_and_ready = 1'b0; idle(2);

        // Disabled sample
        set_thr(32'd1);
        set_refen(8'hF7);
        bus_read(SAD_REFEN, 1);
        check("refen_rb", 32'(rq[0]), 32'hF7);
        base_pattern();
        pat[3] = 8'($urandom);
        armed_and_ready = 1'b1; idle(3); obs_trigs = 0;
        feed(); idle(8);
        check("refen_trigs", 32'(obs_trigs), 32'd1);
        armed_and_ready = 1'b0; idle(2);

        // Multiple triggers
        base_pattern();
        set_refen(8'hFF);
        set_multi(8'h01);
        bus_read(SAD_MULTIPLE_TRIGGERS, 1);
        check("multi_rb", 32'(rq[0]), 32'h01);
        armed_and_ready = 1'b1; idle(3); obs_trigs = 0;
        feed(); idle(30); feed(); idle(8);
        check("multi_trigs", 32'(obs_trigs), 32'd2);
        check_status("multi_status", 8'd1, 8'd2);
        armed_and_ready = 1'b0; idle(2);

        // Single trigger per arm
        set_multi(8'h00);
        armed_and_ready = 1'b1; idle(3); obs_trigs = 0;
        feed(); idle(30); feed(); idle(8);
        check("single_trigs1", 32'(obs_trigs), 32'd1);
        armed_and_ready = 1'b0; idle(2);
        armed_and_ready = 1'b1; idle(3); obs_trigs = 0;
        feed(); idle(8);
        check("single_trigs2", 32'(obs_trigs), 32'd1);
        check_status("single_status", 8'd1, 8'd1);
        armed_and_ready = 1'b0; idle(2);

        // Disarmed, then reset mid-pattern
        set_multi(8'h01);
        obs_trigs = 0;
        feed(); idle(8);
        for (int i = 0; i < NI; i++) pat_q.push_back(pat[i]);
        idle(4);
        do_reset(3);
        pat_q.delete();
        idle(10);
        check("disarm_trigs", 32'(obs_trigs), 32'd0);
        check_status("post_rst_status", 8'd0, 8'd0);
        bus_read(SAD_THRESHOLD, 4);
        check("post_rst_thr", {rq[3], rq[2], rq[1], rq[0]}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sad_wrapper.md
SAD_WRAPPER -- requirements
Module: sad_wrapper

Interface
REQ-001 SHALL have parameter pBYTECNT_SIZE, default 7, width of the per-access byte counter.
REQ-002 SHALL have parameter pREF_SAMPLES, default 8, window length N, a multiple of 8 and at most 512.
REQ-003 SHALL have parameter pBITS_PER_SAMPLE, default 12, ADC sample width (at least 8).
REQ-004 SHALL have port clk_adc, input, 1 bit: the only clock; bus and datapath both run on it.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port adc_datain, input, pBITS_PER_SAMPLE bits: sampled on every clk_adc rising edge.
REQ-007 SHALL have port armed_and_ready, input, 1 bit: triggering is enabled while it is high.
REQ-008 SHALL have ports USB_Addr (input, 8 bits), USB_Data (inout, 8 bits), and USB_RDn, USB_WRn, USB_CEn, USB_ALEn (inputs, 1 bit each, all active-low).
REQ-009 SHALL have port trigger, output, 1 bit: single-cycle match pulse.

Function
REQ-010 SHALL keep a register map in sad_pkg:
- SAD_STATUS 0x60 (read-only)
- SAD_REFERENCE_BASE 0x61
- SAD_REFERENCE 0x62
- SAD_REFEN 0x63
- SAD_THRESHOLD 0x64
- SAD_MULTIPLE_TRIGGERS 0x65
REQ-011 SHALL clear the byte counter on any cycle with USB_ALEn low.
REQ-012 SHALL perform a write on the synchronised falling edge of USB_WRn while USB_CEn is low; each write then increments the byte counter.
REQ-013 SHALL drive USB_Data only while USB_CEn and USB_RDn are both low; each synchronised rising edge of USB_RDn then increments the byte counter.
REQ-014 SHALL, on a SAD_REFERENCE access at byte counter k, address reference sample ref[base*128 + k], where base is SAD_REFERENCE_BASE.
- Each reference sample is 8 bits.
- It is compared against adc_datain[pBITS_PER_SAMPLE-1 -: 8].
REQ-015 SHALL map SAD_REFEN byte k to enable bits refen[8k+7:8k]; refen[i]=0 excludes sample i from the sum.
REQ-016 SHALL map SAD_THRESHOLD as a 32-bit little-endian value, bytes 0..3.
REQ-017 SHALL use bit 0 of SAD_MULTIPLE_TRIGGERS as the multiple-trigger enable.
REQ-018 SHALL make every register except SAD_STATUS read back the value last written.
REQ-019 SHALL shift each clock's 8-bit sample into an N-deep window; window[i] is the sample taken N-1-i clocks before the newest.
REQ-020 SHALL compute, every clock, sum = Σ refen[i]·|window[i] − ref[i]|, at full width with no saturation.
REQ-021 SHALL declare a match when sum < threshold; sum equal to threshold SHALL NOT match.
REQ-022 SHALL NOT evaluate matches until N samples have been shifted in since reset.
REQ-023 SHALL pipeline the datapath with a fixed latency: trigger goes high exactly 5 clocks after the edge that samples the final window element.
REQ-024 SHALL hold trigger high for exactly 1 cycle per match.
REQ-025 SHALL suppress matches while armed_and_ready is low.
REQ-026 SHALL, after any trigger, suppress further triggers until N new samples have entered the window.
REQ-027 SHALL, with multiple-trigger enable = 1, fire on every qualifying match while armed.
REQ-028 SHALL, with multiple-trigger enable = 0, fire at most once per rising edge of armed_and_ready.
REQ-029 SHALL return SAD_STATUS byte 0 = triggered flag: sticky, set by any trigger.
REQ-030 SHALL return SAD_STATUS byte 1 = count of triggers, 8-bit, saturating at 255.
REQ-031 SHALL clear the triggered flag and the trigger count on each rising edge of armed_and_ready.
REQ-032 SHALL let a register write coincident with a match take effect from the next clock only.

Reset
REQ-033 SHALL, on reset_n low, asynchronously clear all of the following to 0:
- trigger
- status flag and trigger count
- window fill count
- base, refen, threshold, multiple-trigger enable
- reference RAM (may be left uninitialised)
REQ-034 SHALL tri-state USB_Data while reset_n is low.

Configuration
REQ-035 SHALL implement the trigger counter only when macro SAD_TRIGGER_COUNT_EN is defined.
- Without it, SAD_STATUS byte 1 reads 0 and the counter logic is absent.
- Triggering behaviour is identical either way.

Structure
REQ-036 SHALL put the register address constants, the reference sample width (8), the threshold width (32) and the status layout in package sad_pkg.
REQ-037 SHALL implement the bus decode, byte counter and register file in one sub-module, sad_usb_reg; the SAD datapath stays in sad_wrapper.

Verification
REQ-038 SHALL cover an exact match:
- Stimulus: ref = 10,20,…,80; refen = 0xFF; threshold = 1; feed the pattern (<<4).
- Response: a single trigger exactly 5 clocks after the last sample.
REQ-039 SHALL cover the threshold boundary:
- Stimulus: same pattern with sample 3 off by +5; threshold 5, then threshold 6.
- Response: no trigger at threshold 5; a trigger at threshold 6.
REQ-040 SHALL cover disabled samples:
- Stimulus: refen = 0xF7, with sample 3 set to random data.
- Response: trigger.
REQ-041 SHALL cover multiple triggers:
- Stimulus: enable = 1; matching pattern sent twice, 30 random samples apart.
- Response: two triggers; STATUS reads 1, 2.
REQ-042 SHALL cover single-trigger re-arm:
- Stimulus: enable = 0; two matches in one arm, then re-arm and one match.
- Response: one trigger per arm; STATUS reads 1, 1.
REQ-043 SHALL cover disarmed input and reset:
- Stimulus: matching pattern with armed_and_ready = 0, then reset_n pulsed mid-pattern.
- Response: no trigger; STATUS reads 0, 0.
